// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte streams.
// Grants are held for a whole packet, bounded by MAX_BURST bytes and GAP_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = 8,
    parameter int MAX_BURST   = 16,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_vld,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_rdy,
    output logic                           uart_tx_vld,
    output logic [DATA_BITS-1:0]           uart_tx_data,
    input  logic                           uart_tx_rdy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           gap_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t               state;
    logic [BW-1:0]        byte_cnt;
    logic [CW-1:0]        gap_cnt;
    logic                 last_q;
    logic [GW-1:0]        pick;
    logic                 cur_vld;
    logic                 accept;
    logic [DATA_BITS-1:0] cur_byte;

    // grant_id doubles as last_grant: it only changes when leaving S_IDLE.
    // Scan offsets high to low so the nearest requester after it wins.
    always_comb begin
        pick = grant_id;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_vld[(int'(grant_id) + k) % NUM_REQ])
                pick = GW'((int'(grant_id) + k) % NUM_REQ);
        end
    end

    assign cur_vld  = req_vld[grant_id];
    assign cur_byte = req_data[int'(grant_id)*DATA_BITS +: DATA_BITS];
    assign accept   = (state == S_ISSUE) && uart_tx_rdy && cur_vld;
    assign busy     = (state != S_IDLE);

    always_comb begin
        req_rdy = '0;
        req_rdy[grant_id] = accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            grant_id     <= GW'(NUM_REQ - 1);
            uart_tx_vld  <= 1'b0;
            uart_tx_data <= '0;
            gap_err      <= 1'b0;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            last_q       <= 1'b0;
        end else begin
            uart_tx_vld <= 1'b0;
            gap_err     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req_vld) begin
                        grant_id <= pick;
                        byte_cnt <= '0;
                        gap_cnt  <= '0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        uart_tx_data <= cur_byte;
                        uart_tx_vld  <= 1'b1;
                        last_q       <= req_last[grant_id];
                        byte_cnt     <= byte_cnt + 1'b1;
                        gap_cnt      <= '0;
                        state        <= S_WAIT_BUSY;
                    end else if (!cur_vld) begin
                        if (gap_cnt >= CW'(GAP_TIMEOUT - 1)) begin
                            gap_err <= 1'b1;
                            gap_cnt <= CW'(GAP_TIMEOUT);
                            state   <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_BUSY: begin
                    if (!uart_tx_rdy)
                        state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (uart_tx_rdy) begin
                        if (last_q || byte_cnt == BW'(MAX_BURST))
                            state <= S_IDLE;
                        else
                            state <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a UART timing model and a
// packet-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DB = 8;
    localparam int MB = 16;
    localparam int GT = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_vld = '0;
    logic [NR*DB-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_rdy;
    logic              uart_tx_vld;
    logic [DB-1:0]     uart_tx_data;
    logic              uart_tx_rdy = 1'b1;
    logic [1:0]        grant_id;
    logic              busy;
    logic              gap_err;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_BITS(DB), .MAX_BURST(MB), .GAP_TIMEOUT(GT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
        .req_rdy(req_rdy),
        .uart_tx_vld(uart_tx_vld), .uart_tx_data(uart_tx_data),
        .uart_tx_rdy(uart_tx_rdy),
        .grant_id(grant_id), .busy(busy), .gap_err(gap_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requester byte queues: {data, last}
    logic [8:0] rq [NR][$];
    int  frame = 4;
    bit  stall = 1'b0;
    int  ucnt = 0;

    int  tx_log[$];
    int  exp_q[$];
    int  exp_gaps;

    int  cyc = 0;
    int  onehot_viol, vld_wide, gap_seen, gap_wide, gap_delta;
    int  rise_cyc, last_acc, min_gap, rdy_seen;
    bit  gap_busy, prev_vld, prev_gap, prev_urdy;

    // UART model: goes busy on a pulse, idle again after `frame` cycles
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                uart_tx_rdy = 1'b1;
                ucnt = 0;
            end else if (stall) begin
                uart_tx_rdy = 1'b0;
            end else if (uart_tx_vld) begin
                uart_tx_rdy = 1'b0;
                ucnt = frame;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) uart_tx_rdy = 1'b1;
            end else begin
                uart_tx_rdy = 1'b1;
            end
        end
    end

    // Requester drivers plus monitor
    initial begin
        logic [8:0] hd;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    hd = rq[i][0];
                    req_vld[i] = 1'b1;
                    req_data[i*DB +: DB] = hd[8:1];
                    req_last[i] = hd[0];
                end else begin
                    req_vld[i] = 1'b0;
                    req_data[i*DB +: DB] = DB'($urandom);
                    req_last[i] = 1'($urandom);
                end
            end
            #1;
            cyc++;
            if ($countones(req_rdy) > 1) onehot_viol++;
            if (req_rdy != '0) begin
                rdy_seen++;
                if (last_acc >= 0 && cyc - last_acc < min_gap)
                    min_gap = cyc - last_acc;
                last_acc = cyc;
            end
            if (uart_tx_vld) begin
                tx_log.push_back(int'(grant_id) * 256 + int'(uart_tx_data));
                if (prev_vld) vld_wide++;
            end
            prev_vld = uart_tx_vld;
            if (gap_err) begin
                gap_seen++;
                gap_delta = cyc - rise_cyc;
                gap_busy = busy;
                if (prev_gap) gap_wide++;
            end
            prev_gap = gap_err;
            if (uart_tx_rdy && !prev_urdy) rise_cyc = cyc;
            prev_urdy = uart_tx_rdy;
            for (int i = 0; i < NR; i++)
                if (req_rdy[i] && !reset && rq[i].size() > 0)
                    void'(rq[i].pop_front());
        end
    end

    task automatic clear_mon();
        tx_log.delete();
        onehot_viol = 0; vld_wide = 0; gap_seen = 0; gap_wide = 0;
        gap_delta = -1; gap_busy = 1'b1; rdy_seen = 0;
        rise_cyc = cyc; last_acc = -1; min_gap = 1000000;
        prev_vld = 1'b0; prev_gap = 1'b0; prev_urdy = uart_tx_rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        stall = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        clear_mon();
    endtask

    // Packet-level model: round robin from the last winner, a grant lasts
    // until a last byte, MAX_BURST bytes, or the stream runs dry (gap error).
    task automatic build_model();
        logic [8:0] m [NR][$];
        logic [8:0] e;
        int lg, pick, n;
        bit any, done;
        for (int i = 0; i < NR; i++) m[i] = rq[i];
        exp_q.delete();
        exp_gaps = 0;
        lg = NR - 1;
        forever begin
            any = 1'b0;
            for (int i = 0; i < NR; i++) if (m[i].size() > 0) any = 1'b1;
            if (!any) break;
            pick = -1;
            for (int k = 1; k <= NR; k++)
                if (pick < 0 && m[(lg + k) % NR].size() > 0) pick = (lg + k) % NR;
            n = 0;
            done = 1'b0;
            while (!done) begin
                if (m[pick].size() == 0) begin
                    exp_gaps++;
                    done = 1'b1;
                end else begin
                    e = m[pick].pop_front();
                    exp_q.push_back(pick * 256 + int'(e[8:1]));
                    n++;
                    if (e[0] || n == MB) done = 1'b1;
                end
            end
            lg = pick;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        bit empty;
        n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            #2;
            n++;
            empty = 1'b1;
            for (int i = 0; i < NR; i++) if (rq[i].size() > 0) empty = 1'b0;
            ok = empty && !busy && tx_log.size() >= exp_q.size();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        checks++;
        if (req_rdy !== '0) begin failures++; $display("FAIL rst_req_rdy got=%b want=0", req_rdy); end
        checks++;
        if (uart_tx_vld !== 1'b0) begin failures++; $display("FAIL rst_tx_vld got=%b want=0", uart_tx_vld); end
        checks++;
        if (uart_tx_data !== '0) begin failures++; $display("FAIL rst_tx_data got=%h want=00", uart_tx_data); end
        checks++;
        if (grant_id !== 2'd3) begin failures++; $display("FAIL rst_grant got=%0d want=3", grant_id); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++;
        if (gap_err !== 1'b0) begin failures++; $display("FAIL rst_gap_err got=%b want=0", gap_err); end
    endtask

    task automatic test_single_packet();
        bit ok;
        do_reset();
        frame = 100;
        rq[1].push_back({8'h41, 1'b0});
        rq[1].push_back({8'h42, 1'b0});
        rq[1].push_back({8'h43, 1'b1});
        build_model();
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout busy=%b sent=%0d want=3", busy, tx_log.size()); end
        checks++;
        if (tx_log.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d want=%0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte[%0d] got=%h want=%h", i, tx_log[i], exp_q[i]); end
        end
        checks++;
        if (grant_id !== 2'd1) begin failures++; $display("FAIL single_grant got=%0d want=1", grant_id); end
        checks++;
        if (uart_tx_data !== 8'h43) begin failures++; $display("FAIL single_hold got=%h want=43", uart_tx_data); end
        checks++;
        if (min_gap < frame + 2) begin failures++; $display("FAIL single_latency got=%0d want>=%0d", min_gap, frame + 2); end
        checks++;
        if (vld_wide != 0) begin failures++; $display("FAIL single_vld_width got=%0d want=0", vld_wide); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        frame = 3;
        for (int r = 0; r < NR; r++)
            for (int p = 0; p < (r < 2 ? 2 : 1); p++)
                rq[r].push_back({8'($urandom), 1'b1});
        build_model();
        wait_idle(500, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_timeout sent=%0d want=%0d", tx_log.size(), exp_q.size()); end
        checks++;
        if (tx_log.size() != exp_q.size()) begin failures++; $display("FAIL rr_count got=%0d want=%0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte[%0d] got=%h want=%h", i, tx_log[i], exp_q[i]); end
        end
        checks++;
        if (onehot_viol != 0) begin failures++; $display("FAIL rr_onehot got=%0d want=0", onehot_viol); end
        checks++;
        if (min_gap < frame + 2) begin failures++; $display("FAIL rr_latency got=%0d want>=%0d", min_gap, frame + 2); end
    endtask

    task automatic test_max_burst();
        bit ok;
        do_reset();
        frame = 2;
        for (int b = 0; b < 20; b++) rq[2].push_back({8'(b + 8'h60), 1'b0});
        rq[3].push_back({8'hA5, 1'b1});
        build_model();
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL burst_timeout sent=%0d want=%0d", tx_log.size(), exp_q.size()); end
        checks++;
        if (tx_log.size() != exp_q.size()) begin failures++; $display("FAIL burst_count got=%0d want=%0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_q[i]) begin failures++; $display("FAIL burst_byte[%0d] got=%h want=%h", i, tx_log[i], exp_q[i]); end
        end
        checks++;
        if (gap_seen != exp_gaps) begin failures++; $display("FAIL burst_gaps got=%0d want=%0d", gap_seen, exp_gaps); end
    endtask

    task automatic test_gap_timeout();
        bit ok;
        do_reset();
        frame = 5;
        rq[0].push_back({8'h10, 1'b0});
        rq[0].push_back({8'h11, 1'b0});
        rq[1].push_back({8'h22, 1'b1});
        build_model();
        wait_idle(500, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL gap_timeout_wait sent=%0d want=%0d", tx_log.size(), exp_q.size()); end
        checks++;
        if (tx_log.size() != exp_q.size()) begin failures++; $display("FAIL gap_count got=%0d want=%0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_q[i]) begin failures++; $display("FAIL gap_byte[%0d] got=%h want=%h", i, tx_log[i], exp_q[i]); end
        end
        checks++;
        if (gap_seen != 1) begin failures++; $display("FAIL gap_pulses got=%0d want=1", gap_seen); end
        checks++;
        if (gap_wide != 0) begin failures++; $display("FAIL gap_width got=%0d want=0", gap_wide); end
        checks++;
        if (gap_delta != GT + 1) begin failures++; $display("FAIL gap_cycle got=%0d want=%0d", gap_delta, GT + 1); end
        checks++;
        if (gap_busy !== 1'b0) begin failures++; $display("FAIL gap_idle busy=%b want=0", gap_busy); end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        frame = 4;
        stall = 1'b1;
        rq[1].push_back({8'h5A, 1'b1});
        build_model();
        repeat (GT * 3) @(negedge clk);
        #2;
        checks++;
        if (rdy_seen != 0) begin failures++; $display("FAIL stall_rdy got=%0d want=0", rdy_seen); end
        checks++;
        if (tx_log.size() != 0) begin failures++; $display("FAIL stall_vld got=%0d want=0", tx_log.size()); end
        checks++;
        if (gap_seen != 0) begin failures++; $display("FAIL stall_gap got=%0d want=0", gap_seen); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b want=1", busy); end
        stall = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_release_timeout sent=%0d want=1", tx_log.size()); end
        checks++;
        if (tx_log.size() != 1 || tx_log[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL stall_release got=%0d bytes want=1 byte %h", tx_log.size(), exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int n;
        do_reset();
        frame = 20;
        rq[1].push_back({8'h31, 1'b0});
        rq[1].push_back({8'h32, 1'b0});
        rq[1].push_back({8'h33, 1'b1});
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            #2;
            n++;
            seen = uart_tx_vld;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_no_pulse got=0 want=1"); end
        reset = 1'b1;
        #1;
        checks++;
        if (req_rdy !== '0) begin failures++; $display("FAIL mid_req_rdy got=%b want=0", req_rdy); end
        checks++;
        if (uart_tx_vld !== 1'b0) begin failures++; $display("FAIL mid_tx_vld got=%b want=0", uart_tx_vld); end
        checks++;
        if (uart_tx_data !== '0) begin failures++; $display("FAIL mid_tx_data got=%h want=00", uart_tx_data); end
        checks++;
        if (grant_id !== 2'd3) begin failures++; $display("FAIL mid_grant got=%0d want=3", grant_id); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", busy); end
        for (int i = 0; i < NR; i++) rq[i].delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        clear_mon();
        rq[2].push_back({8'h72, 1'b1});
        rq[0].push_back({8'h70, 1'b1});
        build_model();
        wait_idle(300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_after_timeout sent=%0d want=2", tx_log.size()); end
        checks++;
        if (tx_log.size() != exp_q.size()) begin failures++; $display("FAIL mid_after_count got=%0d want=%0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_q[i]) begin failures++; $display("FAIL mid_after_byte[%0d] got=%h want=%h", i, tx_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int nb, len, budget;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            frame = $urandom_range(1, 12);
            nb = 0;
            for (int r = 0; r < NR; r++) begin
                for (int p = 0; p < $urandom_range(it == 0 ? 1 : 0, 3); p++) begin
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++)
                        rq[r].push_back({8'($urandom), b == len - 1});
                    nb += len;
                end
            end
            build_model();
            budget = 200 + nb * (frame + 8) + exp_gaps * (GT + 10);
            wait_idle(budget, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand%0d_timeout sent=%0d want=%0d", it, tx_log.size(), exp_q.size()); end
            checks++;
            if (tx_log.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count got=%0d want=%0d", it, tx_log.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
                checks++;
                if (tx_log[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte[%0d] got=%h want=%h", it, i, tx_log[i], exp_q[i]); end
            end
            checks++;
            if (onehot_viol != 0 || vld_wide != 0) begin
                failures++;
                $display("FAIL rand%0d_pulses onehot=%0d wide=%0d want=0/0", it, onehot_viol, vld_wide);
            end
            checks++;
            if (exp_q.size() > 1 && min_gap < frame + 2) begin
                failures++;
                $display("FAIL rand%0d_latency got=%0d want>=%0d", it, min_gap, frame + 2);
            end
            checks++;
            if (gap_seen != exp_gaps) begin failures++; $display("FAIL rand%0d_gaps got=%0d want=%0d", it, gap_seen, exp_gaps); end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_max_burst();
        test_gap_timeout();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
